// File: rtl/blk_mem_pipe_wrapper_if.sv
`timescale 1ns/1ps
// Request/response valid-ready channels between a bus/DMA master and blk_mem_pipe_wrapper.
// The wrapper takes the slave side.
interface blk_mem_pipe_wrapper_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_wstrb;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/blk_mem_pipe_wrapper.sv
`timescale 1ns/1ps
// Pipelined single-port SRAM wrapper: reads land in an in-order FWFT response FIFO READ_LATENCY cycles after accept;
// req_ready drops while RESP_DEPTH reads are outstanding. Define BLK_MEM_PERF_EN for rd_cnt/stall_cnt counters.
module blk_mem_pipe_wrapper #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 3,
  parameter int RESP_DEPTH   = 4
) (
  input  logic                  clk_a,
  input  logic                  arst_aq,
`ifdef BLK_MEM_PERF_EN
  output logic [31:0]           rd_cnt,
  output logic [31:0]           stall_cnt,
`endif
  output logic                  busy,
  blk_mem_pipe_wrapper_if.slave bus
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(RESP_DEPTH);
  localparam logic [PW-1:0] PTR_LAST   = PW'(RESP_DEPTH - 1);

  logic [DATA_WIDTH-1:0]   r_mem      [0:(1<<ADDR_WIDTH)-1];
  logic [READ_LATENCY-1:0] r_pipe_vld;
  logic [DATA_WIDTH-1:0]   r_pipe_dat [0:READ_LATENCY-1];
  logic [DATA_WIDTH-1:0]   r_fifo     [0:RESP_DEPTH-1];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic [CW-1:0]           r_credit;
  logic [DATA_WIDTH-1:0]   r_last_rdata;

  logic w_req_ready;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_push;
  logic w_pop;
  logic w_rsp_valid;

  // Credits cover pipeline plus FIFO, so a push can never find the FIFO full.
  assign w_req_ready = (r_credit < CREDIT_MAX);
  assign w_rd_acc    = bus.req_valid & w_req_ready & ~bus.req_we;
  assign w_wr_acc    = bus.req_valid & w_req_ready &  bus.req_we;
  assign w_push      = r_pipe_vld[READ_LATENCY-1];
  assign w_rsp_valid = (r_count != '0);
  assign w_pop       = w_rsp_valid & bus.rsp_ready;

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = w_rsp_valid ? r_fifo[r_rd_ptr] : r_last_rdata;
  assign busy          = (r_credit != '0);

  function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Storage and data path carry no reset; only the valid/control state is cleared.
  always_ff @(posedge clk_a) begin
    if (w_wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.req_wstrb[b]) begin
          r_mem[bus.req_addr][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
        end
      end
    end
    if (w_rd_acc) begin
      r_pipe_dat[0] <= r_mem[bus.req_addr];
    end
    for (int i = 1; i < READ_LATENCY; i++) begin
      r_pipe_dat[i] <= r_pipe_dat[i-1];
    end
    if (w_push) begin
      r_fifo[r_wr_ptr] <= r_pipe_dat[READ_LATENCY-1];
    end
  end

  always_ff @(posedge clk_a or posedge arst_aq) begin
    if (arst_aq) begin
      r_pipe_vld   <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_credit     <= '0;
      r_last_rdata <= '0;
    end else begin
      r_pipe_vld[0] <= w_rd_acc;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
      end
      if (w_push) begin
        r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr     <= f_ptr_inc(r_rd_ptr);
        r_last_rdata <= r_fifo[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      case ({w_rd_acc, w_pop})
        2'b10:   r_credit <= r_credit + 1'b1;
        2'b01:   r_credit <= r_credit - 1'b1;
        default: r_credit <= r_credit;
      endcase
    end
  end

`ifdef BLK_MEM_PERF_EN
  logic [31:0] r_rd_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk_a or posedge arst_aq) begin
    if (arst_aq) begin
      r_rd_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_rd_acc && (r_rd_cnt != '1)) begin
        r_rd_cnt <= r_rd_cnt + 1'b1;
      end
      if (bus.req_valid && !w_req_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign rd_cnt    = r_rd_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_blk_mem_pipe_wrapper.sv
`timescale 1ns/1ps
// Directed and randomised checks of blk_mem_pipe_wrapper against a transaction-level model:
// a word array for memory plus a queue of outstanding reads stamped with their accept edge.
module tb_blk_mem_pipe_wrapper;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int L     = 3;
  localparam int DEPTH = 4;

  logic clk_a;
  logic arst_aq;
  logic busy;
`ifdef BLK_MEM_PERF_EN
  logic [31:0] rd_cnt;
  logic [31:0] stall_cnt;
`endif

  blk_mem_pipe_wrapper_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  blk_mem_pipe_wrapper #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(L), .RESP_DEPTH(DEPTH)
  ) dut (
    .clk_a     (clk_a),
    .arst_aq   (arst_aq),
`ifdef BLK_MEM_PERF_EN
    .rd_cnt    (rd_cnt),
    .stall_cnt (stall_cnt),
`endif
    .busy      (busy),
    .bus       (bus)
  );

  initial clk_a = 1'b0;
  always #5 clk_a = ~clk_a;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int m_rd     = 0;
  int m_stall  = 0;
  logic [31:0] m_mem [0:4095];
  logic [31:0] q_dat [$];
  int          q_edge[$];

  function automatic bit m_ready();
    return q_dat.size() < DEPTH;
  endfunction

  function automatic bit m_valid();
    return (q_dat.size() != 0) && (q_edge[0] + L <= cyc);
  endfunction

  // Advance one clock; the model applies the handshakes seen just before the edge.
  task automatic tick();
    bit acc, pop, rst_now, we;
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    rst_now = arst_aq;
    acc = !rst_now && bus.req_valid && m_ready();
    pop = !rst_now && bus.rsp_ready && m_valid();
    if (!rst_now && bus.req_valid && !m_ready()) m_stall++;
    we = bus.req_we; a = bus.req_addr; d = bus.req_wdata; s = bus.req_wstrb;
    @(posedge clk_a);
    cyc++;
    if (arst_aq) begin
      q_dat.delete(); q_edge.delete(); m_rd = 0; m_stall = 0;
    end else begin
      if (pop) begin
        void'(q_dat.pop_front()); void'(q_edge.pop_front());
      end
      if (acc && we) begin
        for (int b = 0; b < 4; b++) if (s[b]) m_mem[a][8*b +: 8] = d[8*b +: 8];
      end else if (acc) begin
        q_dat.push_back(m_mem[a]); q_edge.push_back(cyc); m_rd++;
      end
    end
    #1;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = a; bus.req_wdata = d; bus.req_wstrb = s;
    while (!m_ready() && n < 20) begin tick(); n++; end
    tick();
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] a);
    int n = 0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = a; bus.req_wstrb = 4'($urandom);
    while (!m_ready() && n < 20) begin tick(); n++; end
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_head();
    int n = 0;
    while (!m_valid() && n < 20) begin tick(); n++; end
  endtask

  task automatic test_reset();
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_wstrb = '0; bus.rsp_ready = 0;
    arst_aq = 1'b1;
    repeat (3) tick();
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (bus.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus.rsp_rdata); end
`ifdef BLK_MEM_PERF_EN
    n_checks++; if (rd_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_rd_cnt: got %0d expected 0", rd_cnt); end
    n_checks++; if (stall_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
`endif
    arst_aq = 1'b0;
    tick();
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_req_ready: got %b expected 1", bus.req_ready); end
  endtask

  task automatic test_write_read();
    do_write(12'h010, 32'hDEADBEEF, 4'hF);
    bus.rsp_ready = 1'b0;
    do_read(12'h010);
    for (int k = 0; k <= L; k++) begin
      n_checks++; if (bus.rsp_valid !== (k == L)) begin n_fail++; $display("FAIL wr_rd_latency k=%0d: got %b expected %b", k, bus.rsp_valid, (k == L)); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_rd_busy k=%0d: got %b expected 1", k, busy); end
      if (k < L) tick();
    end
    n_checks++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_data: got %h expected deadbeef", bus.rsp_rdata); end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_popped: got %b expected 0", bus.rsp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_rd_idle_busy: got %b expected 0", busy); end
    n_checks++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_hold: got %h expected deadbeef", bus.rsp_rdata); end
  endtask

  task automatic test_wstrb();
    logic [11:0] a;
    logic [31:0] d1, d2;
    logic [3:0]  s;
    a = 12'($urandom_range(256, 511));
    do_write(a, 32'h11223344, 4'hF);
    do_write(a, 32'hAABBCCDD, 4'h5);
    do_read(a);
    wait_head();
    n_checks++; if (bus.rsp_rdata !== 32'h11BB33DD) begin n_fail++; $display("FAIL wstrb_fixed: got %h expected 11bb33dd", bus.rsp_rdata); end
    bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = 12'($urandom_range(256, 511)); d1 = $urandom; d2 = $urandom; s = 4'($urandom);
      do_write(a, d1, 4'hF);
      do_write(a, d2, s);
      do_read(a);
      wait_head();
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== q_dat[0]) begin n_fail++; $display("FAIL wstrb_rand s=%h: got %b/%h expected 1/%h", s, bus.rsp_valid, bus.rsp_rdata, q_dat[0]); end
      bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;
    end
  endtask

  task automatic test_raw();
    logic [11:0] a;
    logic [31:0] d;
    for (int i = 0; i < 6; i++) begin
      a = 12'($urandom_range(512, 767)); d = $urandom;
      do_write(a, d, 4'hF);
      do_read(a);
      wait_head();
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== d) begin n_fail++; $display("FAIL raw_b2b a=%h: got %b/%h expected 1/%h", a, bus.rsp_valid, bus.rsp_rdata, d); end
      bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [8];
    logic [31:0] got_d [$];
    int          got_c [$];
    int          i_req = 0;
    int          first_acc = -1;
    bit          acc;
    for (int i = 0; i < 8; i++) begin
      exp_d[i] = $urandom;
      do_write(12'(i), exp_d[i], 4'hF);
    end
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 40 && (i_req < 8 || got_d.size() < 8); c++) begin
      n_checks++; if (bus.rsp_valid !== m_valid()) begin n_fail++; $display("FAIL b2b_rsp_valid c=%0d: got %b expected %b", c, bus.rsp_valid, m_valid()); end
      n_checks++; if (bus.req_ready !== m_ready()) begin n_fail++; $display("FAIL b2b_req_ready c=%0d: got %b expected %b", c, bus.req_ready, m_ready()); end
      if (bus.rsp_valid === 1'b1) begin got_d.push_back(bus.rsp_rdata); got_c.push_back(cyc); end
      bus.req_valid = (i_req < 8); bus.req_we = 1'b0; bus.req_addr = 12'(i_req);
      acc = (i_req < 8) && m_ready();
      tick();
      if (acc) begin
        if (first_acc < 0) first_acc = cyc;
        i_req++;
      end
    end
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
    n_checks++; if (got_d.size() != 8) begin n_fail++; $display("FAIL b2b_count: got %0d expected 8", got_d.size()); end
    for (int i = 0; i < 8 && i < got_d.size(); i++) begin
      n_checks++; if (got_d[i] !== exp_d[i]) begin n_fail++; $display("FAIL b2b_order i=%0d: got %h expected %h", i, got_d[i], exp_d[i]); end
    end
    if (got_c.size() > 0) begin
      n_checks++; if (got_c[0] != first_acc + L) begin n_fail++; $display("FAIL b2b_first_latency: got edge %0d expected %0d", got_c[0], first_acc + L); end
    end
  endtask

  task automatic test_backpressure();
    int n_acc = 0;
    int k = 0;
    bit acc;
    for (int i = 0; i < 6; i++) do_write(12'h300 + 12'(i), $urandom, 4'hF);
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 12'h300 + 12'(n_acc);
      n_checks++; if (bus.req_ready !== m_ready()) begin n_fail++; $display("FAIL bp_req_ready c=%0d: got %b expected %b", c, bus.req_ready, m_ready()); end
      if (n_acc == DEPTH) begin
        n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full c=%0d: got %b expected 0", c, bus.req_ready); end
      end
      acc = m_ready();
      tick();
      if (acc) n_acc++;
    end
    bus.req_valid = 1'b0;
    n_checks++; if (n_acc != DEPTH) begin n_fail++; $display("FAIL bp_accepts: got %0d expected %0d", n_acc, DEPTH); end
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      n_checks++; if (bus.rsp_valid !== m_valid()) begin n_fail++; $display("FAIL bp_drain_valid c=%0d: got %b expected %b", c, bus.rsp_valid, m_valid()); end
      if (bus.rsp_valid === 1'b1) begin
        n_checks++; if (bus.rsp_rdata !== m_mem[12'h300 + 12'(k)]) begin n_fail++; $display("FAIL bp_drain_data k=%0d: got %h expected %h", k, bus.rsp_rdata, m_mem[12'h300 + 12'(k)]); end
        k++;
      end
      tick();
    end
    bus.rsp_ready = 1'b0;
    n_checks++; if (k != DEPTH) begin n_fail++; $display("FAIL bp_drained: got %0d expected %0d", k, DEPTH); end
    n_checks++; if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got ready=%b busy=%b expected 1/0", bus.req_ready, busy); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d1, d2;
    d1 = $urandom; d2 = $urandom;
    do_write(12'h3A0, d1, 4'hF);
    do_write(12'h3A1, d2, 4'hF);
    bus.rsp_ready = 1'b0;
    do_read(12'h3A0);
    do_read(12'h3A1);
    arst_aq = 1'b1;
    #1;
    q_dat.delete(); q_edge.delete();
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_rsp_valid: got %b expected 0", bus.rsp_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_req_ready: got %b expected 1", bus.req_ready); end
    n_checks++; if (bus.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_rdata: got %h expected 0", bus.rsp_rdata); end
    tick();
    arst_aq = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale c=%0d: got %b expected 0", c, bus.rsp_valid); end
      tick();
    end
    bus.rsp_ready = 1'b0;
    do_read(12'h3A1);
    wait_head();
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== d2) begin n_fail++; $display("FAIL midrst_mem_kept: got %b/%h expected 1/%h", bus.rsp_valid, bus.rsp_rdata, d2); end
    bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int a = 0; a < 32; a++) do_write(12'(a), $urandom, 4'hF);
    for (int c = 0; c < 600; c++) begin
      bus.req_valid = ($urandom_range(0, 9) < 7);
      bus.req_we    = ($urandom_range(0, 9) < 3);
      bus.req_addr  = 12'($urandom_range(0, 31));
      bus.req_wdata = $urandom;
      bus.req_wstrb = 4'($urandom);
      bus.rsp_ready = ($urandom_range(0, 9) < 6);
      n_checks++; if (bus.req_ready !== m_ready()) begin n_fail++; $display("FAIL rnd_req_ready c=%0d: got %b expected %b", c, bus.req_ready, m_ready()); end
      n_checks++; if (bus.rsp_valid !== m_valid()) begin n_fail++; $display("FAIL rnd_rsp_valid c=%0d: got %b expected %b", c, bus.rsp_valid, m_valid()); end
      n_checks++; if (busy !== (q_dat.size() != 0)) begin n_fail++; $display("FAIL rnd_busy c=%0d: got %b expected %b", c, busy, (q_dat.size() != 0)); end
      if (m_valid()) begin
        n_checks++; if (bus.rsp_rdata !== q_dat[0]) begin n_fail++; $display("FAIL rnd_rdata c=%0d: got %h expected %h", c, bus.rsp_rdata, q_dat[0]); end
      end
      tick();
    end
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    repeat (12) tick();
    bus.rsp_ready = 1'b0;
    n_checks++; if (busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_drained: got busy=%b valid=%b expected 0/0", busy, bus.rsp_valid); end
  endtask

`ifdef BLK_MEM_PERF_EN
  task automatic test_perf();
    arst_aq = 1'b1; tick(); arst_aq = 1'b0; tick();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_read(12'(i));
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 12'h004;
    repeat (2) tick();
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    do_read(12'h004);
    bus.rsp_ready = 1'b1;
    repeat (12) tick();
    bus.rsp_ready = 1'b0;
    n_checks++; if (rd_cnt !== 32'd5 || rd_cnt !== 32'(m_rd)) begin n_fail++; $display("FAIL perf_rd_cnt: got %0d expected 5 (model %0d)", rd_cnt, m_rd); end
    n_checks++; if (stall_cnt !== 32'd2 || stall_cnt !== 32'(m_stall)) begin n_fail++; $display("FAIL perf_stall_cnt: got %0d expected 2 (model %0d)", stall_cnt, m_stall); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arst_aq = 1'b1;
    test_reset();
    test_write_read();
    test_wstrb();
    test_raw();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
`ifdef BLK_MEM_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
